// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch front end.
//   XLEN             : width of instructions and byte addresses
//   NOP_INSTR        : bubble instruction (sll $0,$0,0)
//   DEFAULT_RESET_PC : default PC after reset
//   BOOT/RUN/HALTED  : 2-bit fetch FSM encoding, visible on state_o
package fetch_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  localparam logic [1:0] BOOT   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] HALTED = 2'd2;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: instruction, PC+4 and valid flag.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   load              : capture {instrIn, pc4In, valid=1}
//   flush             : write a bubble (NOP_INSTR, pc4 0, valid 0); wins over load
//   instrIn, pc4In    : values to capture
//   instrOut, pc4Out, validOut : registered contents
// With neither load nor flush the contents are held.
module ifid_reg
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            flush,
  input  logic [XLEN-1:0] instrIn,
  input  logic [XLEN-1:0] pc4In,
  output logic [XLEN-1:0] instrOut,
  output logic [XLEN-1:0] pc4Out,
  output logic            validOut
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instrOut <= NOP_INSTR;
      pc4Out   <= '0;
      validOut <= 1'b0;
    end else if (flush) begin
      instrOut <= NOP_INSTR;
      pc4Out   <= '0;
      validOut <= 1'b0;
    end else if (load) begin
      instrOut <= instrIn;
      pc4Out   <= pc4In;
      validOut <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the PC, drives it to instruction memory,
// and captures the returned instruction with PC+4 into the IF/ID register.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   stall_i        : hold PC and IF/ID
//   redirect_i     : load redirect_pc_i (highest priority, also leaves HALTED)
//   redirect_pc_i  : redirect target byte address
//   halt_i         : stop fetching, enter HALTED
//   pc_o           : current PC, instruction memory read address
//   instr_i        : instruction for pc_o (combinational memory)
//   ifid_instr_o, ifid_pc4_o, ifid_valid_o : IF/ID register
//   state_o        : FSM state 0 BOOT, 1 RUN, 2 HALTED
//   misalign_o     : only with MISALIGN_CHECK_EN; one-cycle pulse when a
//                    redirect target had nonzero low bits (target is aligned)
// Optional feature macro: MISALIGN_CHECK_EN
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [XLEN-1:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            halt_i,
  output logic [XLEN-1:0] pc_o,
  input  logic [XLEN-1:0] instr_i,
  output logic [XLEN-1:0] ifid_instr_o,
  output logic [XLEN-1:0] ifid_pc4_o,
  output logic            ifid_valid_o,
  output logic [1:0]      state_o
`ifdef MISALIGN_CHECK_EN
  ,
  output logic            misalign_o
`endif
);

  logic [1:0]      stateQ, stateD;
  logic [XLEN-1:0] pcQ, pcD;
  logic [XLEN-1:0] pcPlus4;
  logic [XLEN-1:0] redirectTarget;
  logic            ifidLoad, ifidFlush;
  logic            takeRedirect;

  assign pcPlus4 = pcQ + 32'd4;

`ifdef MISALIGN_CHECK_EN
  logic misalignQ, misalignD;
  assign redirectTarget = {redirect_pc_i[XLEN-1:2], 2'b00};
  assign misalignD      = takeRedirect && (redirect_pc_i[1:0] != 2'b00);
  assign misalign_o     = misalignQ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalignQ <= 1'b0;
    else        misalignQ <= misalignD;
  end
`else
  assign redirectTarget = redirect_pc_i;
`endif

  // Redirect is honoured in RUN and HALTED, never during the BOOT cycle.
  assign takeRedirect = redirect_i && (stateQ == RUN || stateQ == HALTED);

  always_comb begin
    stateD    = stateQ;
    pcD       = pcQ;
    ifidLoad  = 1'b0;
    ifidFlush = 1'b0;
    case (stateQ)
      BOOT: begin
        stateD    = RUN;
        ifidFlush = 1'b1;
      end
      RUN: begin
        if (redirect_i) begin
          pcD       = redirectTarget;
          ifidFlush = 1'b1;
        end else if (halt_i) begin
          stateD    = HALTED;
          ifidFlush = 1'b1;
        end else if (!stall_i) begin
          pcD      = pcPlus4;
          ifidLoad = 1'b1;
        end
      end
      HALTED: begin
        ifidFlush = 1'b1;
        if (redirect_i) begin
          pcD    = redirectTarget;
          stateD = RUN;
        end
      end
      default: begin
        stateD    = BOOT;
        ifidFlush = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ <= BOOT;
      pcQ    <= RESET_PC;
    end else begin
      stateQ <= stateD;
      pcQ    <= pcD;
    end
  end

  ifid_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_ifid (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ifidLoad),
    .flush    (ifidFlush),
    .instrIn  (instr_i),
    .pc4In    (pcPlus4),
    .instrOut (ifid_instr_o),
    .pc4Out   (ifid_pc4_o),
    .validOut (ifid_valid_o)
  );

  assign pc_o    = pcQ;
  assign state_o = stateQ;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed steps followed by a random
// run, compared against a cycle-level behavioural model of the fetch rules.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i, redirect_i, halt_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] pc_o, instr_i, ifid_instr_o, ifid_pc4_o;
  logic        ifid_valid_o;
  logic [1:0]  state_o;
`ifdef MISALIGN_CHECK_EN
  logic        misalign_o;
`endif

  int nCompared   = 0;
  int nMismatched = 0;

  // Model state: mode 0 boot, 1 run, 2 halted.
  int          mMode;
  logic [31:0] mPc, mInstr, mPc4;
  logic        mValid, mMis;

  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] addr);
    if (addr == 32'h0) return 32'h2008_0005;
    if (addr == 32'h4) return 32'h2009_0003;
    return (addr * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  assign instr_i = memWord(pc_o);

  fetch_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .halt_i        (halt_i),
    .pc_o          (pc_o),
    .instr_i       (instr_i),
    .ifid_instr_o  (ifid_instr_o),
    .ifid_pc4_o    (ifid_pc4_o),
    .ifid_valid_o  (ifid_valid_o),
    .state_o       (state_o)
`ifdef MISALIGN_CHECK_EN
    ,
    .misalign_o    (misalign_o)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    chk({tag, ".pc"}, pc_o, mPc);
    chk({tag, ".state"}, {30'd0, state_o}, mMode[31:0]);
    chk({tag, ".valid"}, {31'd0, ifid_valid_o}, {31'd0, mValid});
    chk({tag, ".instr"}, ifid_instr_o, mInstr);
    if (mValid) chk({tag, ".pc4"}, ifid_pc4_o, mPc4);
`ifdef MISALIGN_CHECK_EN
    chk({tag, ".mis"}, {31'd0, misalign_o}, {31'd0, mMis});
`endif
  endtask

  task automatic modelReset();
    mMode = 0; mPc = 32'h0; mInstr = 32'h0; mPc4 = 32'h0; mValid = 1'b0; mMis = 1'b0;
  endtask

  // Apply inputs, advance one clock edge in the model and DUT, then check.
  task automatic cycle(input logic s, input logic r, input logic [31:0] t, input logic h,
                       input string tag);
    logic [31:0] tgt;
    stall_i = s; redirect_i = r; redirect_pc_i = t; halt_i = h;
`ifdef MISALIGN_CHECK_EN
    tgt = t & 32'hFFFF_FFFC;
`else
    tgt = t;
`endif
    mMis = 1'b0;
    if (mMode == 0) begin
      mMode = 1; mInstr = 32'h0; mValid = 1'b0;
    end else if (mMode == 1) begin
      if (r) begin
        mPc = tgt; mInstr = 32'h0; mValid = 1'b0; mMis = (t[1:0] != 2'b00);
      end else if (h) begin
        mMode = 2; mInstr = 32'h0; mValid = 1'b0;
      end else if (!s) begin
        mInstr = memWord(mPc); mPc4 = mPc + 32'd4; mValid = 1'b1; mPc = mPc + 32'd4;
      end
    end else begin
      mInstr = 32'h0; mValid = 1'b0;
      if (r) begin
        mPc = tgt; mMode = 1; mMis = (t[1:0] != 2'b00);
      end
    end
    @(posedge clk);
    #1;
    checkAll(tag);
  endtask

  initial begin
    rst_n = 1'b0; stall_i = 0; redirect_i = 0; halt_i = 0; redirect_pc_i = 32'h0;
    modelReset();
    #12;
    checkAll("reset");
    rst_n = 1'b1;

    cycle(0, 0, 0, 0, "boot");
    cycle(0, 0, 0, 0, "fetch0");
    chk("fetch0.exact", ifid_instr_o, 32'h2008_0005);
    cycle(0, 0, 0, 0, "fetch4");
    chk("fetch4.exact", ifid_instr_o, 32'h2009_0003);
    chk("fetch4.pc4", ifid_pc4_o, 32'h8);
    cycle(1, 0, 0, 0, "stall1");
    cycle(1, 0, 0, 0, "stall2");
    chk("stall2.pc", pc_o, 32'h8);
    cycle(0, 0, 0, 0, "release");
    chk("release.pc", pc_o, 32'hC);
    cycle(1, 1, 32'h40, 0, "redirStall");
    cycle(0, 0, 0, 0, "at40");
    cycle(0, 1, 32'h10, 0, "to16");
    cycle(1, 0, 0, 1, "halt");
    cycle(1, 0, 0, 0, "halted1");
    cycle(0, 0, 0, 1, "halted2");
    cycle(0, 0, 0, 0, "halted3");
    cycle(0, 1, 32'h0, 0, "unhalt");
    cycle(0, 0, 0, 0, "runAfterHalt");
    cycle(0, 1, 32'hFFFF_FFFC, 0, "toTop");
    cycle(0, 0, 0, 0, "wrap");
    chk("wrap.pc", pc_o, 32'h0);
    chk("wrap.pc4", ifid_pc4_o, 32'h0);

    for (int i = 0; i < 300; i++) begin
      logic [31:0] rnd;
      rnd = $urandom;
      cycle(rnd[1:0] == 2'b00, rnd[5:2] == 4'h0, $urandom, rnd[8:6] == 3'b000, "rand");
    end

    // Asynchronous reset between edges.
    cycle(0, 0, 0, 0, "preReset");
    #2 rst_n = 1'b0;
    #1;
    modelReset();
    checkAll("asyncReset");
    #4 rst_n = 1'b1;
    cycle(0, 0, 0, 0, "boot2");
    cycle(0, 0, 0, 0, "fetchAgain");

`ifdef MISALIGN_CHECK_EN
    cycle(0, 1, 32'h42, 0, "misRedirect");
    chk("misRedirect.pc", pc_o, 32'h40);
    cycle(0, 0, 0, 0, "misClear");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch front end of the CPU datapath.
- Owns the program counter and drives it as the byte address into the instruction memory, which returns a 32-bit instruction combinationally in the same cycle.
- Captures that instruction, with PC+4, into the IF/ID pipeline register consumed by decode/control.
- Handles stall, redirect (branch/jump), halt and boot sequencing.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, bubble instruction written into IF/ID (sll $0,$0,0).

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- stall_i  input  1  hold PC and IF/ID (hazard unit).
- redirect_i  input  1  taken branch/jump; load redirect_pc_i.
- redirect_pc_i  input  32  redirect target byte address.
- halt_i  input  1  stop fetching (halt instruction decoded).
- pc_o  output  32  current PC; drives instruction memory readAddress.
- instr_i  input  32  instruction returned by memory for pc_o.
- ifid_instr_o  output  32  registered instruction to decode.
- ifid_pc4_o  output  32  registered PC+4 of that instruction.
- ifid_valid_o  output  1  1 = IF/ID holds a real instruction.
- state_o  output  2  FSM state (debug): 0 BOOT, 1 RUN, 2 HALTED.

Behaviour:
- Reset (async, rst_n=0): pc_o=RESET_PC, ifid_instr_o=NOP_INSTR, ifid_pc4_o=0, ifid_valid_o=0, state=BOOT. Reset asserted mid-operation discards all in-flight state immediately.
- BOOT: lasts exactly one cycle after rst_n deasserts. PC held, IF/ID stays bubble, then goes to RUN. The first real fetch of RESET_PC is captured at the end of the first RUN cycle.
- RUN, each posedge, in priority order:
  1. redirect_i: PC<=redirect_pc_i; IF/ID<=bubble (NOP, valid 0). Overrides stall_i and halt_i.
  2. halt_i: PC held; IF/ID<=bubble; state<=HALTED.
  3. stall_i: PC and IF/ID (instr, pc4, valid) all held unchanged.
  4. Otherwise: IF/ID<={instr_i, pc_o+4, valid=1}; PC<=pc_o+4.
- HALTED: PC frozen; IF/ID bubble; stall_i ignored. Only redirect_i (PC<=target, state<=RUN, IF/ID bubble) or reset exits.
- Latency: instruction at address A appears on ifid_instr_o exactly one cycle after pc_o==A, absent stall.
- Arithmetic: PC+4 is 32-bit modulo; 32'hFFFF_FFFC wraps to 0 with no flag.
- redirect_pc_i is used as given; alignment is not enforced unless the optional feature is enabled.
- Outputs pc_o, ifid_* and state_o are registered; no combinational path from instr_i to any output.

Optional Feature:
- Macro MISALIGN_CHECK_EN.
- Defined: adds output misalign_o (1 bit, reset 0). On a redirect whose redirect_pc_i[1:0]!=0, PC loads {redirect_pc_i[31:2],2'b00} and misalign_o pulses high for one cycle.
- Undefined: port absent; target loaded unmodified.

Decomposition:
- Shared package fetch_pkg:
  - NOP_INSTR constant.
  - Default RESET_PC.
  - State encoding constants BOOT/RUN/HALTED (2-bit).
  - Width constant for instruction and address (32).
- One natural sub-module, ifid_reg: holds instr/pc4/valid with load, hold and flush controls and async active-low reset. PC register and FSM stay in fetch_stage.

Test Plan:
- Reset then free-run; memory returns 32'h2008_0005 at 0 and 32'h2009_0003 at 4 → pc_o 0,0(BOOT),4,8. ifid_instr_o=32'h2008_0005 with ifid_pc4_o=4, valid=1 one cycle after pc_o=0; next cycle 32'h2009_0003 with pc4=8.
- stall_i high 2 cycles while pc_o=8 → pc_o stays 8 and IF/ID unchanged for 2 cycles, resumes with pc_o=12 after release.
- redirect_i=1 with redirect_pc_i=32'h40 and stall_i=1 in the same cycle → next pc_o=32'h40, ifid_valid_o=0, ifid_instr_o=0; following cycle captures instr at 32'h40.
- halt_i at pc_o=16 → state_o=2, pc_o stays 16, valid=0 indefinitely; later redirect_i to 32'h0 → state_o=1, pc_o=0.
- Force pc_o=32'hFFFF_FFFC via redirect, run one cycle → pc_o=0, ifid_pc4_o=0, valid=1.
- rst_n pulled low asynchronously mid-run (between edges) → pc_o=RESET_PC and valid=0 immediately. With MISALIGN_CHECK_EN, redirect to 32'h42 gives pc_o=32'h40 and a one-cycle misalign_o pulse.
